if_stage: RTL and testbench

Instruction-fetch stage of the five-stage ARM pipeline: it owns the program counter, issues word fetches to the instruction memory over a req/ready handshake, and drives the IF/ID pipeline register that feeds instruction decode. It sends instructions in the forward direction; decode consumes them and returns the `hazard` freeze. Execute returns the taken-branch redirect. Also provides a one-entry skid buffer so a fetch completing during a freeze is not lost.

---
 rtl/if_stage.sv | 206 ++++++++++++++++++++
 tb/tb_if_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage - instruction-fetch stage of the five-stage ARM pipeline.
//
// Owns the program counter, issues word fetches over a req/ready handshake
// and drives the IF/ID pipeline register. A one-entry skid buffer captures a
// fetch that completes while decode holds the freeze, so it is not refetched.
// A taken branch from execute squashes IF/ID and redirects the PC; a request
// already on the bus when the branch lands is drained in DISCARD and its data
// dropped.
//
// Optional feature macro: IF_STALL_COUNT_EN
//   defined   : stall_count counts freeze cycles (freeze=1, branch_taken=0),
//               saturating at all-ones, cleared only by reset.
//   undefined : stall_count is tied to 0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   freeze             hazard stall from decode
//   branch_taken       one-cycle redirect pulse from execute
//   branch_address     redirect target (bits [1:0] ignored)
//   imem_req/addr      registered fetch request and word-aligned byte address
//   imem_ready/rdata   request completion and fetched word
//   pc_out             IF/ID: address of held instruction + 4
//   instruction        IF/ID: fetched word
//   valid_out          IF/ID: 0 = bubble
//   stall_count        freeze-cycle counter
//
// state   | meaning
// IDLE    | out of reset, first request issued next edge
// FETCH   | request outstanding, waiting for imem_ready
// HOLD    | fetched word parked in skid buffer while decode is frozen
// DISCARD | draining a request made stale by a branch
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid_out,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_pc_out, w_pc_out_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] r_skid_data, w_skid_data_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;

  logic [31:0] w_pc_inc;
  logic [31:0] w_br_tgt;
  logic        w_pend_open;

  assign w_pc_inc    = r_pc + 32'd4;
  assign w_br_tgt    = branch_address & ~32'h0000_0003;
  // A request on the bus that has not completed this cycle cannot be
  // withdrawn; a branch must wait it out in DISCARD.
  assign w_pend_open = r_req & ~imem_ready;

  // State register plus all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_pc_out     <= 32'd0;
      r_instr      <= 32'd0;
      r_valid      <= 1'b0;
      r_skid_pc    <= 32'd0;
      r_skid_data  <= 32'd0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_pc_out     <= w_pc_out_nxt;
      r_instr      <= w_instr_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (branch_taken) begin
      w_state_nxt = w_pend_open ? S_DISCARD : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_FETCH;
        S_FETCH:   if (imem_ready && freeze) w_state_nxt = S_HOLD;
        S_HOLD:    if (!freeze) w_state_nxt = S_FETCH;
        S_DISCARD: if (imem_ready) w_state_nxt = S_FETCH;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    w_pc_nxt         = r_pc;
    w_req_nxt        = r_req;
    w_addr_nxt       = r_addr;
    w_pc_out_nxt     = r_pc_out;
    w_instr_nxt      = r_instr;
    w_valid_nxt      = r_valid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_data_nxt  = r_skid_data;
    w_skid_valid_nxt = r_skid_valid;
    if (branch_taken) begin
      w_pc_nxt         = w_br_tgt;
      w_pc_out_nxt     = 32'd0;
      w_instr_nxt      = 32'd0;
      w_valid_nxt      = 1'b0;
      w_skid_valid_nxt = 1'b0;
      if (!w_pend_open) begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = w_br_tgt;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = r_pc;
        end
        S_FETCH: begin
          if (imem_ready) begin
            w_pc_nxt = w_pc_inc;
            if (freeze) begin
              w_skid_pc_nxt    = w_pc_inc;
              w_skid_data_nxt  = imem_rdata;
              w_skid_valid_nxt = 1'b1;
              w_req_nxt        = 1'b0;
            end else begin
              w_pc_out_nxt = w_pc_inc;
              w_instr_nxt  = imem_rdata;
              w_valid_nxt  = 1'b1;
              w_req_nxt    = 1'b1;
              w_addr_nxt   = w_pc_inc;
            end
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            w_pc_out_nxt     = r_skid_pc;
            w_instr_nxt      = r_skid_data;
            w_valid_nxt      = r_skid_valid;
            w_skid_valid_nxt = 1'b0;
            w_req_nxt        = 1'b1;
            w_addr_nxt       = r_pc;
          end
        end
        S_DISCARD: begin
          if (imem_ready) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = r_pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_STALL_COUNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (freeze && !branch_taken && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
  assign stall_count = r_stall_cnt;
`else
  assign stall_count = 32'd0;
`endif

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign pc_out      = r_pc_out;
  assign instruction = r_instr;
  assign valid_out   = r_valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid_out;
  logic [31:0] stall_count;

  int n_chk  = 0;
  int n_pass = 0;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instruction    (instruction),
    .valid_out      (valid_out),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] ba;
    logic        rdy;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pco;
    logic [31:0] ins;
    logic        vld;
    logic [31:0] stl;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  // memory data pattern: word at address a
  function automatic logic [31:0] dw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] ba,
                              input logic rdy, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr,
                              input logic [31:0] pco, input logic [31:0] ins,
                              input logic vld, input logic [31:0] stl);
    vec_t v;
    v.frz = frz; v.br = br; v.ba = ba; v.rdy = rdy; v.rd = rd;
    v.req = req; v.addr = addr; v.pco = pco; v.ins = ins; v.vld = vld; v.stl = stl;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_stall(input logic [31:0] s);
`ifdef IF_STALL_COUNT_EN
    return s;
`else
    return (s == s) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic drive(input logic frz, input logic br, input logic [31:0] ba,
                       input logic rdy, input logic [31:0] rd);
    freeze = frz; branch_taken = br; branch_address = ba;
    imem_ready = rdy; imem_rdata = rd;
  endtask

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    // frz br  ba            rdy rd           | req addr          pc_out        instr              vld stall
    vt[0]  = mk(0, 0, 0,            0, JUNK,          1, 32'h0,         32'h0,   32'h0,             0, 0);
    vt[1]  = mk(0, 0, 0,            1, dw(32'h0),     1, 32'h4,         32'h4,   dw(32'h0),         1, 0);
    vt[2]  = mk(0, 0, 0,            1, dw(32'h4),     1, 32'h8,         32'h8,   dw(32'h4),         1, 0);
    vt[3]  = mk(0, 0, 0,            1, dw(32'h8),     1, 32'hC,         32'hC,   dw(32'h8),         1, 0);
    vt[4]  = mk(0, 0, 0,            1, dw(32'hC),     1, 32'h10,        32'h10,  dw(32'hC),         1, 0);
    vt[5]  = mk(1, 0, 0,            0, JUNK,          1, 32'h10,        32'h10,  dw(32'hC),         1, 1);
    vt[6]  = mk(1, 0, 0,            1, dw(32'h10),    0, 32'h10,        32'h10,  dw(32'hC),         1, 2);
    vt[7]  = mk(1, 0, 0,            0, JUNK,          0, 32'h10,        32'h10,  dw(32'hC),         1, 3);
    vt[8]  = mk(0, 0, 0,            0, JUNK,          1, 32'h14,        32'h14,  dw(32'h10),        1, 3);
    vt[9]  = mk(0, 0, 0,            0, JUNK,          1, 32'h14,        32'h14,  dw(32'h10),        1, 3);
    vt[10] = mk(0, 1, 32'h100,      0, JUNK,          1, 32'h14,        32'h0,   32'h0,             0, 3);
    vt[11] = mk(0, 0, 0,            0, JUNK,          1, 32'h14,        32'h0,   32'h0,             0, 3);
    vt[12] = mk(0, 0, 0,            1, dw(32'h14),    1, 32'h100,       32'h0,   32'h0,             0, 3);
    vt[13] = mk(0, 0, 0,            1, dw(32'h100),   1, 32'h104,       32'h104, dw(32'h100),       1, 3);
    vt[14] = mk(1, 1, 32'h41,       1, dw(32'h104),   1, 32'h40,        32'h0,   32'h0,             0, 3);
    vt[15] = mk(0, 0, 0,            1, dw(32'h40),    1, 32'h44,        32'h44,  dw(32'h40),        1, 3);
    vt[16] = mk(1, 0, 0,            0, JUNK,          1, 32'h44,        32'h44,  dw(32'h40),        1, 4);
    vt[17] = mk(1, 0, 0,            0, JUNK,          1, 32'h44,        32'h44,  dw(32'h40),        1, 5);
    vt[18] = mk(1, 0, 0,            0, JUNK,          1, 32'h44,        32'h44,  dw(32'h40),        1, 6);
    vt[19] = mk(1, 0, 0,            0, JUNK,          1, 32'h44,        32'h44,  dw(32'h40),        1, 7);
    vt[20] = mk(1, 0, 0,            0, JUNK,          1, 32'h44,        32'h44,  dw(32'h40),        1, 8);
    vt[21] = mk(0, 0, 0,            1, dw(32'h44),    1, 32'h48,        32'h48,  dw(32'h44),        1, 8);
    vt[22] = mk(1, 0, 0,            1, dw(32'h48),    0, 32'h48,        32'h48,  dw(32'h44),        1, 9);
    vt[23] = mk(1, 1, 32'h200,      0, JUNK,          1, 32'h200,       32'h0,   32'h0,             0, 9);
    vt[24] = mk(0, 0, 0,            1, dw(32'h200),   1, 32'h204,       32'h204, dw(32'h200),       1, 9);
    vt[25] = mk(0, 1, 32'h300,      0, JUNK,          1, 32'h204,       32'h0,   32'h0,             0, 9);
    vt[26] = mk(0, 1, 32'hFFFF_FFFC,0, JUNK,          1, 32'h204,       32'h0,   32'h0,             0, 9);
    vt[27] = mk(0, 0, 0,            1, dw(32'h204),   1, 32'hFFFF_FFFC, 32'h0,   32'h0,             0, 9);
    vt[28] = mk(0, 0, 0,            1, dw(32'hFFFF_FFFC), 1, 32'h0,     32'h0,   32'h5A5A_FFFC,     1, 9);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check32("rst.req",   {31'd0, imem_req},  32'd0);
    check32("rst.addr",  imem_addr,          32'd0);
    check32("rst.pcout", pc_out,             32'd0);
    check32("rst.instr", instruction,        32'd0);
    check32("rst.valid", {31'd0, valid_out}, 32'd0);
    check32("rst.stall", stall_count,        32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].frz, vt[i].br, vt[i].ba, vt[i].rdy, vt[i].rd);
      @(posedge clk);
      #1;
      check32($sformatf("v%0d.req", i),   {31'd0, imem_req},  {31'd0, vt[i].req});
      check32($sformatf("v%0d.addr", i),  imem_addr,          vt[i].addr);
      check32($sformatf("v%0d.pcout", i), pc_out,             vt[i].pco);
      check32($sformatf("v%0d.instr", i), instruction,        vt[i].ins);
      check32($sformatf("v%0d.valid", i), {31'd0, valid_out}, {31'd0, vt[i].vld});
      check32($sformatf("v%0d.stall", i), stall_count,        exp_stall(vt[i].stl));
      @(negedge clk);
    end

    // Reset asserted mid-request: outputs return to reset values at once.
    drive(0, 0, 0, 0, JUNK);
    #2;
    rst = 1'b1;
    #1;
    check32("midrst.req",   {31'd0, imem_req},  32'd0);
    check32("midrst.addr",  imem_addr,          32'd0);
    check32("midrst.pcout", pc_out,             32'd0);
    check32("midrst.instr", instruction,        32'd0);
    check32("midrst.valid", {31'd0, valid_out}, 32'd0);
    check32("midrst.stall", stall_count,        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First request one cycle after release.
    @(posedge clk);
    #1;
    check32("first.req",  {31'd0, imem_req}, 32'd1);
    check32("first.addr", imem_addr,         32'd0);
    @(negedge clk);

    // Wait states: ready low for 3 cycles per fetch.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        drive(0, 0, 0, 0, JUNK);
        @(posedge clk);
        #1;
        check32($sformatf("ws%0d.%0d.addr", k, w), imem_addr, 32'(4 * k));
        check32($sformatf("ws%0d.%0d.req", k, w), {31'd0, imem_req}, 32'd1);
        check32($sformatf("ws%0d.%0d.pcout", k, w), pc_out, 32'(4 * k));
        @(negedge clk);
      end
      drive(0, 0, 0, 1, dw(32'(4 * k)));
      @(posedge clk);
      #1;
      check32($sformatf("ws%0d.pcout", k), pc_out,             32'(4 * k + 4));
      check32($sformatf("ws%0d.instr", k), instruction,        dw(32'(4 * k)));
      check32($sformatf("ws%0d.valid", k), {31'd0, valid_out}, 32'd1);
      check32($sformatf("ws%0d.next", k),  imem_addr,          32'(4 * k + 4));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
